// File: rtl/led_pkg.sv
// Shared types for the LED PWM driver: channel mode encoding.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_STEADY  = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: pending/active config shadow, breathe ramp and registered PWM compare.
// Optional gamma correction of the effective duty when LED_GAMMA_EN is defined.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_mode_i,
  input  logic [PWM_W-1:0] wr_duty_i,
  input  logic             boundary_i,
  input  logic             phase_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  output logic             pending_o,
  output logic             led_oe_o
);

  led_mode_t        pend_mode_q, pend_mode_d, act_mode_q, act_mode_d;
  logic [PWM_W-1:0] pend_duty_q, pend_duty_d, act_duty_q, act_duty_d;
  logic [PWM_W-1:0] ramp_q, ramp_d;
  logic             pend_q, pend_d, ramp_up_q, ramp_up_d, led_oe_q, led_oe_d;
  logic [PWM_W-1:0] duty, duty_eff;

  always_comb begin
    pend_mode_d = pend_mode_q;
    pend_duty_d = pend_duty_q;
    pend_d      = pend_q;
    act_mode_d  = act_mode_q;
    act_duty_d  = act_duty_q;
    ramp_d      = ramp_q;
    ramp_up_d   = ramp_up_q;
    if (boundary_i) begin
      if (pend_q) begin
        act_mode_d = pend_mode_q;
        act_duty_d = pend_duty_q;
        pend_d     = 1'b0;
      end
      // Ramp restarts on entry to BREATHE and is clamped when a lower peak arrives.
      if (act_mode_d != LED_BREATHE || (pend_q && act_mode_q != LED_BREATHE)) begin
        ramp_d    = '0;
        ramp_up_d = 1'b1;
      end else if (pend_q && (pend_duty_q < ramp_q)) begin
        ramp_d    = pend_duty_q;
        ramp_up_d = 1'b0;
      end else if (act_duty_d == '0) begin
        ramp_d    = '0;
        ramp_up_d = 1'b1;
      end else if (ramp_up_q) begin
        if (ramp_q < act_duty_d) begin
          ramp_d = ramp_q + PWM_W'(1);
        end else begin
          ramp_d    = ramp_q - PWM_W'(1);
          ramp_up_d = 1'b0;
        end
      end else if (ramp_q != '0) begin
        ramp_d = ramp_q - PWM_W'(1);
      end else begin
        ramp_d    = ramp_q + PWM_W'(1);
        ramp_up_d = 1'b1;
      end
    end
    // A write on the boundary cycle becomes the next pending value.
    if (wr_en_i) begin
      pend_mode_d = led_mode_t'(wr_mode_i);
      pend_duty_d = wr_duty_i;
      pend_d      = 1'b1;
    end
  end

  always_comb begin
    duty = '0;
    unique case (act_mode_q)
      LED_OFF:     duty = '0;
      LED_STEADY:  duty = act_duty_q;
      LED_BLINK:   duty = phase_i ? '0 : act_duty_q;
      LED_BREATHE: duty = ramp_q;
      default:     duty = '0;
    endcase
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_W-1:0] duty_sq;
  assign duty_sq  = {{PWM_W{1'b0}}, duty} * {{PWM_W{1'b0}}, duty};
  assign duty_eff = duty_sq[2*PWM_W-1:PWM_W];
`else
  assign duty_eff = duty;
`endif

  // Full-scale duty is always on, judged before gamma.
  assign led_oe_d = (duty == '1) | (pwm_cnt_i < duty_eff);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_mode_q <= LED_OFF;
      pend_duty_q <= '0;
      pend_q      <= 1'b0;
      act_mode_q  <= LED_OFF;
      act_duty_q  <= '0;
      ramp_q      <= '0;
      ramp_up_q   <= 1'b1;
      led_oe_q    <= 1'b0;
    end else begin
      pend_mode_q <= pend_mode_d;
      pend_duty_q <= pend_duty_d;
      pend_q      <= pend_d;
      act_mode_q  <= act_mode_d;
      act_duty_q  <= act_duty_d;
      ramp_q      <= ramp_d;
      ramp_up_q   <= ramp_up_d;
      led_oe_q    <= led_oe_d;
    end
  end

  assign pending_o = pend_q;
  assign led_oe_o  = led_oe_q;

endmodule

// File: rtl/led_pwm_driver.sv
// Multi-channel LED PWM driver: shared prescaler, PWM and blink timebase, config handshake.
// Define LED_GAMMA_EN to square-law correct each channel's duty.
module led_pwm_driver #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned PRESCALE = 188,
  parameter int unsigned BLINK_W  = 8,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_48mhz,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic [NUM_CH-1:0] led_oe,
  output logic              frame_end
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]    prescale_q, prescale_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               frame_end_q;
  logic               tick, boundary;
  logic [NUM_CH-1:0]  pend;

  assign tick     = (prescale_q == PS_W'(PRESCALE - 1));
  assign boundary = tick && (pwm_cnt_q == '1);

  always_comb begin
    prescale_d  = tick ? '0 : prescale_q + PS_W'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
    blink_cnt_d = boundary ? blink_cnt_q + BLINK_W'(1) : blink_cnt_q;
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      prescale_q  <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      frame_end_q <= 1'b0;
    end else begin
      prescale_q  <= prescale_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      frame_end_q <= boundary;
    end
  end

  // Out-of-range channels stay ready so their writes are silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i] | boundary;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_W(PWM_W)
    ) u_ch (
      .clk_i     (clk_48mhz),
      .rst_ni    (reset_n),
      .wr_en_i   (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))),
      .wr_mode_i (cfg_mode),
      .wr_duty_i (cfg_duty),
      .boundary_i(boundary),
      .phase_i   (blink_cnt_q[BLINK_W-1]),
      .pwm_cnt_i (pwm_cnt_q),
      .pending_o (pend[i]),
      .led_oe_o  (led_oe[i])
    );
  end

  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver at NUM_CH=3, PWM_W=4, PRESCALE=2, BLINK_W=2.
module tb_led_pwm_driver;
  import led_pkg::*;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned PWM_W    = 4;
  localparam int unsigned PRESCALE = 2;
  localparam int unsigned BLINK_W  = 2;
  localparam int          FRAME    = PRESCALE << PWM_W;

  logic              clk_48mhz = 1'b0;
  logic              reset_n   = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch    = '0;
  logic [1:0]        cfg_mode  = '0;
  logic [PWM_W-1:0]  cfg_duty  = '0;
  logic [NUM_CH-1:0] led_oe;
  logic              frame_end;

  int n_checks = 0;
  int n_fail   = 0;
  int frames   = 0;
  int on_cnt[NUM_CH];
  logic [NUM_CH-1:0] trace[FRAME];
  int w;

  always #5 clk_48mhz = ~clk_48mhz;

  led_pwm_driver #(
    .NUM_CH  (NUM_CH),
    .PWM_W   (PWM_W),
    .PRESCALE(PRESCALE),
    .BLINK_W (BLINK_W)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset_n  (reset_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_duty (cfg_duty),
    .led_oe   (led_oe),
    .frame_end(frame_end)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples per frame that a channel with effective duty d is lit.
  function automatic int exp_on(input int d);
    int g;
    if (d == (1 << PWM_W) - 1) return FRAME;
`ifdef LED_GAMMA_EN
    g = (d * d) >> PWM_W;
`else
    g = d;
`endif
    return g * PRESCALE;
  endfunction

  task automatic measure_frame();
    int fe = 0;
    for (int c = 0; c < NUM_CH; c++) on_cnt[c] = 0;
    for (int s = 0; s < FRAME; s++) begin
      @(negedge clk_48mhz);
      trace[s] = led_oe;
      for (int c = 0; c < NUM_CH; c++) if (led_oe[c]) on_cnt[c]++;
      if (frame_end) fe++;
    end
    frames++;
    check("frame_end_once", fe, 1);
    check("frame_end_last", int'(frame_end), 1);
  endtask

  task automatic sync_frame(output int waited);
    waited = 0;
    for (int c = 0; c < NUM_CH; c++) on_cnt[c] = 0;
    do begin
      @(negedge clk_48mhz);
      waited++;
      for (int c = 0; c < NUM_CH; c++) if (led_oe[c]) on_cnt[c]++;
    end while (!frame_end && waited < 2 * FRAME);
    check("sync_frame_end", int'(frame_end), 1);
    frames++;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [PWM_W-1:0] duty, output int waits);
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_duty  = duty;
    cfg_valid = 1'b1;
    waits     = 0;
    #1;
    while (!cfg_ready && waits < 2 * FRAME) begin
      @(negedge clk_48mhz);
      waits++;
    end
    check("cfg_accept", int'(cfg_ready), 1);
    @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk_48mhz);
    check("rst_led_oe", int'(led_oe), 0);
    check("rst_frame_end", int'(frame_end), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    reset_n = 1'b1;
    frames  = 0;

    // Out-of-range channel write is dropped; three idle frames
    write_cfg(2'd3, LED_STEADY, 4'd15, w);
    check("oor_wait", w, 0);
    sync_frame(w);
    check("first_frame_end", w, FRAME - 1);
    for (int c = 0; c < NUM_CH; c++) check("idle_sync_on", on_cnt[c], 0);
    check("idle_cfg_ready", int'(cfg_ready), 1);
    repeat (2) begin
      measure_frame();
      for (int c = 0; c < NUM_CH; c++) check("idle_on", on_cnt[c], 0);
    end

    // ch0 STEADY 4 written mid-frame
    repeat (10) @(negedge clk_48mhz);
    write_cfg(2'd0, LED_STEADY, 4'd4, w);
    check("steady_wait", w, 0);
    sync_frame(w);
    check("steady_before_boundary", on_cnt[0], 0);
    measure_frame();
    check("steady_on", on_cnt[0], exp_on(4));
    check("steady_s0", int'(trace[0][0]), int'(exp_on(4) > 0));
    check("steady_s7", int'(trace[7][0]), int'(exp_on(4) > 7));
    check("steady_s8", int'(trace[8][0]), int'(exp_on(4) > 8));
    check("steady_s31", int'(trace[31][0]), 0);

    // Back-to-back writes to ch1
    repeat (5) @(negedge clk_48mhz);
    write_cfg(2'd1, LED_STEADY, 4'd8, w);
    check("b2b_first_wait", w, 0);
    write_cfg(2'd1, LED_STEADY, 4'd2, w);
    check("b2b_second_wait", w, 25);
    check("b2b_on_boundary", int'(frame_end), 1);
    frames++;
    measure_frame();
    check("b2b_first_on", on_cnt[1], exp_on(8));
    check("b2b_ch0_on", on_cnt[0], exp_on(4));
    measure_frame();
    check("b2b_second_on", on_cnt[1], exp_on(2));

    // ch2 BLINK 15: blink_cnt counts boundaries since reset
    write_cfg(2'd2, LED_BLINK, 4'd15, w);
    sync_frame(w);
    check("blink_before", on_cnt[2], 0);
    for (int f = 0; f < 4; f++) begin
      int e;
      e = ((frames % 4) >= 2) ? 0 : exp_on(15);
      measure_frame();
      check("blink_on", on_cnt[2], e);
    end

    // ch0 BREATHE peak 3, then peak 1 while ramp=3
    write_cfg(2'd0, LED_BREATHE, 4'd3, w);
    sync_frame(w);
    check("breathe_pre", on_cnt[0], exp_on(4) - 1);
    for (int f = 0; f < 3; f++) begin
      measure_frame();
      check("breathe_up", on_cnt[0], exp_on(f));
    end
    write_cfg(2'd0, LED_BREATHE, 4'd1, w);
    sync_frame(w);
    check("breathe_peak", on_cnt[0], exp_on(3) - int'(exp_on(3) > 0));
    measure_frame();
    check("breathe_reload", on_cnt[0], exp_on(1));
    measure_frame();
    check("breathe_down", on_cnt[0], exp_on(0));
    measure_frame();
    check("breathe_up_again", on_cnt[0], exp_on(1));

    // Mid-frame reset discards active and pending config
    repeat (7) @(negedge clk_48mhz);
    write_cfg(2'd1, LED_STEADY, 4'd15, w);
    repeat (3) @(negedge clk_48mhz);
    check("pending_not_ready", int'(cfg_ready), 0);
    reset_n = 1'b0;
    @(negedge clk_48mhz);
    check("midrst_led_oe", int'(led_oe), 0);
    check("midrst_frame_end", int'(frame_end), 0);
    check("midrst_ready", int'(cfg_ready), 1);
    reset_n = 1'b1;
    frames  = 0;
    sync_frame(w);
    check("midrst_first_frame", w, FRAME);
    for (int c = 0; c < NUM_CH; c++) check("midrst_sync_on", on_cnt[c], 0);
    measure_frame();
    for (int c = 0; c < NUM_CH; c++) check("midrst_on", on_cnt[c], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
